// File: rtl/lbist_test_sequencer_if.sv
// lbist_test_sequencer_if: control/status bundle between the LBIST sequencer and its test harness.
interface lbist_test_sequencer_if #(
    parameter int ADDR_W = 4
);
    logic START;
    logic test_mode;
    logic BIST_mode;
    logic recovery_done;
    logic test_type;
    logic [ADDR_W-1:0] test_counter;
    logic [1:0] td_pe_select;
    logic scan_en;
    logic acc_wr_en;
    logic dlc_start_en;
    logic detection_en;
    logic weight_start;
    logic busy;
    logic done;
    logic [ADDR_W-1:0] acc_wr_addr;
    modport master (
        output START, test_mode, BIST_mode, recovery_done,
        input test_type, test_counter, td_pe_select, scan_en, acc_wr_en,
        input dlc_start_en, detection_en, weight_start, busy, done, acc_wr_addr
    );
    modport slave (
        input START, test_mode, BIST_mode, recovery_done,
        output test_type, test_counter, td_pe_select, scan_en, acc_wr_en,
        output dlc_start_en, detection_en, weight_start, busy, done, acc_wr_addr
    );
endinterface

// File: rtl/lbist_test_sequencer.sv
// lbist_test_sequencer: LBIST SA/TD pattern sequencer with diagnosis and BISR hand-off; TD phase built only with STRAIT_TD_TEST_EN.
module lbist_test_sequencer #(
    parameter int SYSTOLIC_SIZE = 8,
    parameter int SA_TEST_PATTERN_DEPTH = 12,
    parameter int TD_TEST_PATTERN_DEPTH = 16,
    parameter int MAX_PATTERN_ADDR_WIDTH = $clog2(TD_TEST_PATTERN_DEPTH)
) (
    input logic clk,
    input logic rst,
    lbist_test_sequencer_if.slave bus
);
    localparam int W = MAX_PATTERN_ADDR_WIDTH;
    localparam int CW = $clog2(SYSTOLIC_SIZE + 1);
    localparam logic [CW-1:0] S_LAST = CW'(SYSTOLIC_SIZE - 1);
    localparam logic [W-1:0] SA_LAST = W'(SA_TEST_PATTERN_DEPTH - 1);
`ifdef STRAIT_TD_TEST_EN
    localparam logic [W-1:0] TD_LAST = W'(TD_TEST_PATTERN_DEPTH - 1);
`endif
    typedef enum logic [3:0] {
        IDLE, SA_SHIFT, SA_CAPT, TD_SHIFT, TD_LAUNCH, TD_CAPT,
        DIAG_START, DIAG, REPAIR, WAIT_REC, DONE
    } state_t;
    state_t state, nxt;
    logic [CW-1:0] cnt, cnt_n;
    logic [W-1:0] tc, tc_n;
    logic capt_n, td_n;
    assign tc = bus.test_counter;
    always_comb begin
        nxt = state;
        cnt_n = '0;
        tc_n = tc;
        case (state)
            IDLE: nxt = (bus.START && bus.test_mode && bus.BIST_mode) ? SA_SHIFT : IDLE;
            SA_SHIFT: if (cnt == S_LAST) nxt = SA_CAPT; else cnt_n = cnt + CW'(1);
            SA_CAPT: begin
                tc_n = (tc == SA_LAST) ? '0 : tc + W'(1);
`ifdef STRAIT_TD_TEST_EN
                nxt = (tc == SA_LAST) ? TD_SHIFT : SA_SHIFT;
`else
                nxt = (tc == SA_LAST) ? DIAG_START : SA_SHIFT;
`endif
            end
`ifdef STRAIT_TD_TEST_EN
            TD_SHIFT: if (cnt == S_LAST) nxt = TD_LAUNCH; else cnt_n = cnt + CW'(1);
            TD_LAUNCH: nxt = TD_CAPT;
            TD_CAPT: begin
                tc_n = (tc == TD_LAST) ? '0 : tc + W'(1);
                nxt = (tc == TD_LAST) ? DIAG_START : TD_SHIFT;
            end
`endif
            DIAG_START: nxt = DIAG;
            DIAG: if (cnt == S_LAST) nxt = REPAIR; else cnt_n = cnt + CW'(1);
            REPAIR: nxt = WAIT_REC;
            WAIT_REC: nxt = bus.recovery_done ? DONE : WAIT_REC;
            DONE: nxt = IDLE;
            default: nxt = IDLE;
        endcase
        // dropping test_mode mid-run abandons everything without reporting completion
        if (bus.busy && !bus.test_mode) begin
            nxt = IDLE;
            tc_n = '0;
            cnt_n = '0;
        end
    end
    assign capt_n = (nxt == SA_CAPT) || (nxt == TD_CAPT);
`ifdef STRAIT_TD_TEST_EN
    assign td_n = (nxt == TD_SHIFT) || (nxt == TD_LAUNCH) || (nxt == TD_CAPT);
`else
    assign td_n = 1'b0;
`endif
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt <= '0;
            bus.test_counter <= '0;
            bus.test_type <= 1'b0;
            bus.td_pe_select <= 2'b0;
            bus.scan_en <= 1'b0;
            bus.acc_wr_en <= 1'b0;
            bus.acc_wr_addr <= '0;
            bus.dlc_start_en <= 1'b0;
            bus.detection_en <= 1'b0;
            bus.weight_start <= 1'b0;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
        end else begin
            state <= nxt;
            cnt <= cnt_n;
            bus.test_counter <= tc_n;
            bus.test_type <= td_n;
            bus.td_pe_select <= td_n ? tc_n[1:0] : 2'b0;
            bus.scan_en <= (nxt == SA_SHIFT) || (nxt == TD_SHIFT);
            bus.acc_wr_en <= capt_n;
            bus.acc_wr_addr <= capt_n ? tc_n : '0;
            bus.dlc_start_en <= nxt == DIAG_START;
            bus.detection_en <= nxt == DIAG;
            bus.weight_start <= nxt == REPAIR;
            bus.busy <= (nxt != IDLE) && (nxt != DONE);
            bus.done <= (nxt == DONE) || (bus.done && nxt == IDLE);
        end
    end
endmodule
